// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, owner encoding,
// timeout read-data default and the grant tie-break helper.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } arbState_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Data wins unless round-robin is active and data owned the last grant.
    function automatic logic dataWins(
        input logic   iReq,
        input logic   dReq,
        input owner_t last,
        input logic   rrEn
    );
        return dReq & (~iReq | ~rrEn | (last == OWNER_INST));
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts granted cycles, clears on completion.
// Ports: clk, rst, active (grant held), clear (completion), expired.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !active) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th granted cycle.
    assign expired = active && (count == LAST);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between fetch and data paths with a watchdog.
// Ports: inst_*/data_* requesters, mem_* memory port, stall, timeout_err.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module cpu_mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ack,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wen,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        timeout_err
);

    arbState_t   state;
    logic        busy;
    logic        expired;
    logic        done;
    logic        forced;
    logic        takeData;
    logic        takeInst;
    logic [31:0] respData;

    assign busy     = (state != ARB_IDLE);
    assign done     = busy & (mem_ack | expired);
    assign forced   = busy & expired & ~mem_ack;
    assign respData = mem_ack ? mem_rdata : TIMEOUT_DATA;

    assign inst_ack   = done & (state == ARB_GNT_I);
    assign data_ack   = done & (state == ARB_GNT_D);
    assign inst_rdata = inst_ack ? respData : '0;
    assign data_rdata = data_ack ? respData : '0;

    assign stall = (inst_req & ~inst_ack) | (data_req & ~data_ack);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t lastGrant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= OWNER_DATA;
        end else if (done) begin
            lastGrant <= (state == ARB_GNT_D) ? OWNER_DATA : OWNER_INST;
        end
    end

    assign takeData = dataWins(inst_req, data_req, lastGrant, 1'b1);
`else
    assign takeData = dataWins(inst_req, data_req, OWNER_DATA, 1'b0);
`endif

    assign takeInst = inst_req & ~takeData;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) uWatchdog (
        .clk    (clk),
        .rst    (rst),
        .active (busy),
        .clear  (done),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            mem_req     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_sel     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (forced) begin
                timeout_err <= 1'b1;
            end
            unique case (state)
                ARB_IDLE: begin
                    unique case (1'b1)
                        takeData: begin
                            state     <= ARB_GNT_D;
                            mem_req   <= 1'b1;
                            mem_wen   <= data_wen;
                            mem_sel   <= data_sel;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                        end
                        takeInst: begin
                            state     <= ARB_GNT_I;
                            mem_req   <= 1'b1;
                            mem_wen   <= 1'b0;
                            mem_sel   <= 4'hF;
                            mem_addr  <= inst_addr;
                            mem_wdata <= '0;
                        end
                        default: ;
                    endcase
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    if (done) begin
                        state   <= ARB_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized scoreboard bench for cpu_mem_arbiter.
// Honours ARB_ROUND_ROBIN_EN in its reference model.
module tb_cpu_mem_arbiter;

    localparam int TMO   = 8;
    localparam int NEVER = 1000;
    localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wen = 1'b0;
    logic [3:0]  data_sel = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic        timeout_err;

    cpu_mem_arbiter #(
        .TIMEOUT(TMO),
        .TIMEOUT_DATA(TDATA)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen),
        .data_sel(data_sel), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        logic [31:0] addr;
        bit          wen;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    exp_t expQ[$];
    int   latQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    bit   monOn   = 1'b0;
    bit   modelErr = 1'b0;
    bit   lastWasData = 1'b1;

    function automatic logic [31:0] readModel(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2402_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int expCycles(input exp_t e);
        return (e.lat >= TMO) ? TMO : e.lat + 1;
    endfunction

    function automatic logic [31:0] expRdata(input exp_t e);
        return (e.lat >= TMO) ? TDATA : readModel(e.addr);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: acks the n-th cycle of each request per latQ.
    initial begin
        bit active = 1'b0;
        int rc = 0;
        int curLat = NEVER;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                active = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    rc = 0;
                    curLat = (latQ.size() > 0) ? latQ.pop_front() : NEVER;
                end
                if (rc == curLat) begin
                    mem_ack = 1'b1;
                    mem_rdata = readModel(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                rc++;
            end else begin
                active = 1'b0;
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks request fields, ack timing/data, stall, error flag.
    initial begin
        bit   prevReq = 1'b0;
        int   reqCycles = 0;
        bit   expI;
        bit   expD;
        bit   tmo;
        logic [31:0] expRd;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!monOn) begin
                prevReq = 1'b0;
                reqCycles = 0;
                continue;
            end
            chk("timeout_err", timeout_err, modelErr);
            if (mem_req) begin
                if (!prevReq) begin
                    reqCycles = 1;
                    chk("pending_txn", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        e = expQ[0];
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wen", mem_wen, e.wen);
                        chk("mem_sel", mem_sel, e.sel);
                        if (e.isData) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    reqCycles++;
                end
            end
            prevReq = mem_req;
            expI = 0;
            expD = 0;
            tmo = 0;
            expRd = '0;
            if (mem_req && expQ.size() > 0 && reqCycles == expCycles(expQ[0])) begin
                e = expQ.pop_front();
                if (e.isData) expD = 1; else expI = 1;
                expRd = expRdata(e);
                tmo = (e.lat >= TMO);
            end
            chk("inst_ack", inst_ack, expI);
            chk("data_ack", data_ack, expD);
            chk("inst_rdata", inst_rdata, expI ? expRd : 32'h0);
            chk("data_rdata", data_rdata, expD ? expRd : 32'h0);
            chk("stall", stall, (inst_req & ~expI) | (data_req & ~expD));
            if (tmo) modelErr = 1'b1;
        end
    end

    task automatic pushTxn(input exp_t e);
        expQ.push_back(e);
        latQ.push_back(e.lat);
    endtask

    task automatic runRound(input bit doI, input bit doD,
                            input logic [31:0] iA, input logic [31:0] dA,
                            input logic [31:0] dWd, input logic [3:0] dSel,
                            input bit dWen, input int iLat, input int dLat);
        exp_t ei;
        exp_t ed;
        bit   dFirst;
        ei.isData = 0; ei.addr = iA; ei.wen = 0; ei.sel = 4'hF;
        ei.wdata = '0; ei.lat = iLat;
        ed.isData = 1; ed.addr = dA; ed.wen = dWen; ed.sel = dSel;
        ed.wdata = dWd; ed.lat = dLat;
`ifdef ARB_ROUND_ROBIN_EN
        dFirst = !lastWasData;
`else
        dFirst = 1'b1;
`endif
        if (doI && doD) begin
            if (dFirst) begin
                pushTxn(ed); pushTxn(ei); lastWasData = 0;
            end else begin
                pushTxn(ei); pushTxn(ed); lastWasData = 1;
            end
        end else if (doI) begin
            pushTxn(ei); lastWasData = 0;
        end else if (doD) begin
            pushTxn(ed); lastWasData = 1;
        end
        @(posedge clk);
        #1;
        inst_addr = iA;
        data_addr = dA;
        data_wdata = dWd;
        data_sel = dSel;
        data_wen = dWen;
        inst_req = doI;
        data_req = doD;
        for (int c = 0; c < 100 && (inst_req || data_req); c++) begin
            @(negedge clk);
            if (inst_ack) inst_req = 0;
            if (data_ack) data_req = 0;
        end
        if (inst_req || data_req) begin
            nChecks++;
            nFails++;
            $display("FAIL round_done: reqs %b%b still pending, required none",
                     inst_req, data_req);
            inst_req = 0;
            data_req = 0;
        end
    endtask

    function automatic int pickLat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r == 6) return TMO - 1;
        if (r == 7) return TMO - 2;
        if (r == 8) return NEVER;
        return 5;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation ran away");
        $fatal(1, "global timeout");
    end

    initial begin
        exp_t ed;
        rst = 1'b1;
        inst_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {inst_ack, data_ack}, 0);
        chk("rst_rdata", inst_rdata | data_rdata, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_stall_hi", stall, 1);
        inst_req = 1'b0;
        #1;
        chk("rst_stall_lo", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        monOn = 1'b1;

        // Tie: default data first; round-robin fetch first, then data.
        runRound(1, 1, 32'h200, 32'h100, 32'h1234_5678, 4'b0011, 1, 0, 0);
        runRound(1, 1, 32'h204, 32'h100, 32'h1234_5678, 4'b0011, 1, 0, 0);
        // Single fetch with 3-cycle memory latency.
        runRound(1, 0, 32'h40, 0, 0, 4'h0, 0, 3, 0);
        // Forced completion, then a normal one.
        runRound(1, 0, 32'h80, 0, 0, 4'h0, 0, NEVER, 0);
        runRound(0, 1, 0, 32'h300, 32'hCAFE_F00D, 4'hF, 0, 0, 1);
        // Idle with noisy mem_ack.
        repeat (10) @(posedge clk);

        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 2);
            runRound(k != 1, k != 0,
                     $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                     $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), pickLat(), pickLat());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset while a data transaction is granted.
        ed.isData = 1; ed.addr = 32'h500; ed.wen = 1; ed.sel = 4'hF;
        ed.wdata = 32'h0BAD_0BAD; ed.lat = NEVER;
        pushTxn(ed);
        @(posedge clk);
        #1;
        data_addr = ed.addr;
        data_wdata = ed.wdata;
        data_sel = ed.sel;
        data_wen = ed.wen;
        data_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        #2;
        monOn = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_data_ack", data_ack, 0);
        chk("arst_terr", timeout_err, 0);
        chk("arst_stall", stall, 1);
        data_req = 1'b0;
        expQ.delete();
        latQ.delete();
        modelErr = 1'b0;
        lastWasData = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_req", mem_req, 0);
            chk("rst_hold_ack", data_ack, 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        monOn = 1'b1;
        repeat (2) @(negedge clk);
        runRound(0, 1, 0, 32'h500, 32'h0BAD_0BAD, 4'hF, 1, 0, 2);
        runRound(1, 1, 32'h600, 32'h700, 32'h1, 4'h1, 0, 1, 1);
        repeat (3) @(posedge clk);
        chk("queue_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares one memory port between the pipeline's instruction fetch and data access paths. It grants the port to one requester at a time, forwards the memory's completion back to that requester, and raises `stall` while any pipeline request is outstanding. A watchdog bounds every memory transaction. The block sits between the `mips` core's `instr`/`data_ram_*` ports and a single-ported RAM or bus bridge.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles a granted transaction waits for `mem_ack` before being force-completed.
- `TIMEOUT_DATA`, default 32'hDEAD_BEEF: read data returned on a forced completion.

Ports (all single clock domain):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_req` in 1: fetch request; held high until `inst_ack`.
- `inst_addr` in 32: fetch byte address; stable while `inst_req`.
- `inst_ack` out 1: one-cycle completion pulse.
- `inst_rdata` out 32: fetched word; valid only with `inst_ack`.
- `data_req` in 1: load/store request; held until `data_ack`.
- `data_wen` in 1: 1 = store, 0 = load.
- `data_sel` in 4: byte enables.
- `data_addr` in 32: data address.
- `data_wdata` in 32: store data.
- `data_ack` out 1: one-cycle completion pulse.
- `data_rdata` out 32: load data; valid only with `data_ack`.
- `mem_req` out 1: memory request; held until `mem_ack` or timeout.
- `mem_wen` out 1: memory write enable.
- `mem_sel` out 4: memory byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `stall` out 1: pipeline freeze.
- `timeout_err` out 1: sticky error flag; set on any forced completion.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- **IDLE**
  - `mem_req`=0.
  - If `data_req` is high, go to GNT_D. Otherwise, if `inst_req` is high, go to GNT_I.
  - On that edge, latch the winner's addr/sel/wen/wdata into the `mem_*` registers. A fetch latches `mem_wen`=0 and `mem_sel`=4'hF.
- **GNT_I / GNT_D**
  - `mem_req`=1 from the latched registers.
  - The watchdog counter increments each cycle.
  - On `mem_ack`: pulse the owner's ack combinationally in the same cycle, pass `mem_rdata` through to the owner's rdata, clear the counter, return to IDLE.
  - If the counter reaches `TIMEOUT-1` without `mem_ack`: pulse the owner's ack with rdata=`TIMEOUT_DATA`, set `timeout_err`, drop `mem_req` at the next edge, return to IDLE.
- Ack and rdata of the non-owner are 0.
- Priority without the configuration macro: data always wins a simultaneous request.
- `stall` = (`inst_req` & ~`inst_ack`) | (`data_req` & ~`data_ack`). This is combinational.
- `mem_ack` in IDLE is ignored.
- A requester that drops `req` before ack violates protocol. The transaction still completes to memory, and the ack is still pulsed.
- Counter width is $clog2(TIMEOUT+1). It never wraps because it clears on every completion.
- `timeout_err` clears only on reset.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`, `mem_wen` = 0; `mem_sel` = 0; `mem_addr`, `mem_wdata` = 0.
  - Counter = 0; `timeout_err` = 0.
  - Acks = 0; rdata = 0.
  - `stall` follows the inputs.
- Reset asserted mid-transaction: `mem_req` drops asynchronously, no ack is issued, and the requester reissues after reset.
- Latency: request seen in IDLE at cycle 0 → `mem_req` high at cycle 1. Ack is in the same cycle as `mem_ack`, so the minimum is cycle 1 if memory acks immediately.
- One mandatory IDLE cycle follows every completion, so back-to-back transactions take at least 2 cycles each.
- Timeout ack fires in the `TIMEOUT`-th cycle of `mem_req` high.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A `last_grant` flop (reset = DATA) records the owner of each completed transaction.
  - On a simultaneous request in IDLE, the grant goes to the requester that was not `last_grant`. The first tie after reset goes to instruction.
  - A lone request is granted regardless of `last_grant`.
- Not defined: fixed data priority, and no `last_grant` flop exists.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_GNT_I`, `ARB_GNT_D`);
  - the owner encoding;
  - `TIMEOUT_DATA`'s default.
- One natural sub-module: `arb_watchdog`. It contains the counter, clears on completion, and outputs `expired`.

## Test plan
- Single fetch, `inst_addr`=0x0000_0040, `mem_ack` 3 cycles after `mem_req` with rdata 0x2402_0005 → `inst_ack` pulses once with 0x2402_0005, `stall` low next cycle, `mem_wen`=0, `mem_sel`=4'hF.
- `inst_req` and `data_req` (store 0x1234_5678 to 0x100, sel 4'b0011) rise together, immediate acks → default build: data served first, `mem_wen`=1; fetch granted after one IDLE cycle.
- Same stimulus with `ARB_ROUND_ROBIN_EN` defined → fetch first; on a repeat of the tie, data first.
- Memory never acks, `TIMEOUT`=8 → after 8 cycles of `mem_req`, owner ack with 0xDEAD_BEEF, `timeout_err`=1 and sticky; the next transaction completes normally.
- `rst` asserted while in GNT_D → `mem_req`=0 immediately, no `data_ack`, `timeout_err`=0, state IDLE.
- `mem_ack` pulsed while IDLE with no requests → no ack outputs, state unchanged.
